// File: rtl/seq_det_multi.sv
// Runtime-programmable multi-channel serial pattern detector; hit counters added by SEQ_DET_MULTI_CNT_EN.
// Latency: detected_o pulses one cycle after the edge that accepts the completing bit.
// Backpressure: none; every valid_i bit is consumed, clr_i flushes the stream state.
module seq_det_multi #(
    parameter int MAX_WIDTH = 8,
    parameter int NUM_PAT   = 4,
    parameter int IDX_W     = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1,
    parameter int CNT_WIDTH = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         valid_i,
    input  logic                         data_i,
    input  logic                         clr_i,
    input  logic                         cfg_we_i,
    input  logic [IDX_W-1:0]             cfg_idx_i,
    input  logic                         cfg_en_i,
    input  logic                         cfg_ovl_i,
    input  logic [$clog2(MAX_WIDTH):0]   cfg_len_i,
    input  logic [MAX_WIDTH-1:0]         cfg_pattern_i,
    input  logic [MAX_WIDTH-1:0]         cfg_mask_i,
`ifdef SEQ_DET_MULTI_CNT_EN
    output logic [NUM_PAT*CNT_WIDTH-1:0] cnt_o,
`endif
    output logic [NUM_PAT-1:0]           detected_o
);

    localparam int LEN_W = $clog2(MAX_WIDTH) + 1;

    if (MAX_WIDTH < 2) begin : g_chk_mw
        $error("MAX_WIDTH must be at least 2");
    end
    if (NUM_PAT < 1) begin : g_chk_np
        $error("NUM_PAT must be at least 1");
    end
    if (CNT_WIDTH < 1) begin : g_chk_cw
        $error("CNT_WIDTH must be at least 1");
    end

    // The oldest history bit is never needed again, so only MAX_WIDTH-1 bits are stored.
    logic [MAX_WIDTH-2:0] hist_q;
    logic [LEN_W-1:0]     fill_q;
    logic [MAX_WIDTH-1:0] hist_next;
    logic [LEN_W-1:0]     fill_next;
    logic                 accept;
    logic [LEN_W-1:0]     cfg_len_clamped;
    logic [NUM_PAT-1:0]   hit;

    assign accept    = valid_i && !clr_i;
    assign hist_next = {hist_q, data_i};
    assign fill_next = (fill_q == LEN_W'(MAX_WIDTH)) ? fill_q : fill_q + LEN_W'(1);
    assign cfg_len_clamped = ((cfg_len_i == '0) || (cfg_len_i > LEN_W'(MAX_WIDTH)))
                             ? LEN_W'(MAX_WIDTH) : cfg_len_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (clr_i) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (valid_i) begin
            hist_q <= hist_next[MAX_WIDTH-2:0];
            fill_q <= fill_next;
        end
    end

    for (genvar k = 0; k < NUM_PAT; k++) begin : g_ch
        logic                 en_q;
        logic                 ovl_q;
        logic [LEN_W-1:0]     len_q;
        logic [LEN_W-1:0]     blk_q;
        logic [MAX_WIDTH-1:0] pat_q;
        logic [MAX_WIDTH-1:0] msk_q;
        logic [MAX_WIDTH-1:0] len_mask;
        logic                 match;
        logic                 wr;

        assign wr       = cfg_we_i && (cfg_idx_i == IDX_W'(k));
        assign len_mask = {MAX_WIDTH{1'b1}} >> (LEN_W'(MAX_WIDTH) - len_q);
        assign match    = en_q && (fill_next >= len_q) &&
                          (((hist_next ^ pat_q) & msk_q & len_mask) == '0);
        assign hit[k]   = accept && match && (ovl_q || (blk_q == '0));

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                en_q  <= 1'b0;
                ovl_q <= 1'b1;
                len_q <= LEN_W'(MAX_WIDTH);
                pat_q <= '0;
                msk_q <= '1;
            end else if (wr) begin
                en_q  <= cfg_en_i;
                ovl_q <= cfg_ovl_i;
                len_q <= cfg_len_clamped;
                pat_q <= cfg_pattern_i;
                msk_q <= cfg_mask_i;
            end
        end

        // Non-overlap blocking: after a hit, the next len-1 accepted bits cannot complete a match.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                blk_q <= '0;
            end else if (clr_i || wr) begin
                blk_q <= '0;
            end else if (accept) begin
                if (hit[k] && !ovl_q) begin
                    blk_q <= len_q - LEN_W'(1);
                end else if (blk_q != '0) begin
                    blk_q <= blk_q - LEN_W'(1);
                end
            end
        end

`ifdef SEQ_DET_MULTI_CNT_EN
        logic [CNT_WIDTH-1:0] cnt_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q <= '0;
            end else if (clr_i || wr) begin
                cnt_q <= '0;
            end else if (hit[k] && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
        end

        assign cnt_o[k*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            detected_o <= '0;
        end else begin
            detected_o <= hit;
        end
    end

endmodule
